srl_iter: RTL and testbench

// Multi-cycle 32-bit right shifter (logical or arithmetic) for the ALU shift unit.

---
 rtl/srl_iter.sv | 83 ++++++++
 tb/tb_srl_iter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/srl_iter.sv
// srl_iter: multi-cycle right shifter (logical or arithmetic) for the ALU
// shift unit. Shifts the captured operand one bit per clock, so a request
// with shift amount N completes N+1 cycles after it is accepted.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   start   request; sampled only while idle (busy=0)
//   in      operand, captured on an accepted start
//   select  shift amount 0..WIDTH-1, captured on an accepted start
//   arith   1 = arithmetic (sign fill), 0 = logical (zero fill)
//   out     result; updated only on completion, held otherwise
//   busy    high from the cycle after accept until done asserts
//   done    single-cycle completion pulse, coincident with new out
module srl_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   select,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             mode;
  logic             fill;

  // Bit shifted in at the top: replicated sign for arithmetic, zero otherwise.
  always_comb begin
    fill = mode & acc[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= in;
            cnt   <= select;
            mode  <= arith;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            acc <= {fill, acc[WIDTH-1:1]};
            cnt <= cnt - 1'b1;
          end else begin
            out   <= acc;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srl_iter.sv
module tb_srl_iter;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic [4:0]  select;
  logic        arith;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int ops_issued;
  int done_seen;

  srl_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (in),
    .select (select),
    .arith  (arith),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  // Count every completion pulse the DUT produces.
  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for done after an accept edge; returns number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                        input logic ar, input logic [31:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; in = a; select = s; arith = ar;
    @(posedge clk); #1;
    start = 1'b0;
    ops_issued++;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, n, s + 32'd1);
    chk({tag, "_out"}, out, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a, e;
    logic [4:0]  s;
    logic        ar;
    checks = 0; errors = 0; ops_issued = 0; done_seen = 0;
    clk_en = 1'b0;
    rst = 1'b0; start = 1'b0; in = '0; select = '0; arith = 1'b0;

    // 1. asynchronous reset with no clock edges
    #2 rst = 1'b1;
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #5 rst = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);

    // 2-4. directed shifts
    run_op("log4",   32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
    run_op("ari4",   32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000);
    run_op("ari31",  32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run_op("log31",  32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    run_op("sel0",   32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF);
    run_op("ari0",   32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF);

    // 5. start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; in = 32'h0000_00F0; select = 5'd4; arith = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; ops_issued++;
    @(posedge clk); #1;
    start = 1'b1; in = 32'hFFFF_FFFF; select = 5'd1; arith = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in = 32'h0; select = 5'd0;
    n = 2;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_lat", n, 32'd5);
    chk("ign_out", out, 32'h0000_000F);
    start = 1'b1; in = 32'h1234_5678; select = 5'd8; arith = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; ops_issued++;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b_lat", n, 32'd9);
    chk("b2b_out", out, 32'h0012_3456);

    // 6. reset mid-operation
    @(negedge clk);
    start = 1'b1; in = 32'hFFFF_0000; select = 5'd20; arith = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", out, 32'h0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    chk("abort_nodone", done_seen, ops_issued);
    run_op("post_rst", 32'h8765_4321, 5'd20, 1'b1, 32'hFFFF_F876);

    // 7. sweep against the shift operators
    for (int i = 0; i <= 510; i += 3) begin
      a  = (i << 23) | i;
      s  = 5'(i % 32);
      ar = ((i / 3) % 2) == 1;
      e  = ar ? 32'($signed(a) >>> s) : (a >> s);
      run_op("sweep", a, s, ar, e);
    end
    chk("score", done_seen, ops_issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
